// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: operand width, ALU op encoding and arbiter FSM states.
package alu_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLT  = 4'd9
  } op_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/execute.sv
// Combinational integer ALU; unknown op codes produce zero.
module execute
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = alu_pkg::XLEN
) (
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [3:0]      op_sel_i,
  output logic [XLEN-1:0] res_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;

  assign w_shamt = opr_b_i[SHW-1:0];

  always_comb begin
    res_o = '0;
    case (op_sel_i)
      OP_ADD:  res_o = opr_a_i + opr_b_i;
      OP_SUB:  res_o = opr_a_i - opr_b_i;
      OP_SLL:  res_o = opr_a_i << w_shamt;
      OP_SRL:  res_o = opr_a_i >> w_shamt;
      OP_SRA:  res_o = XLEN'($signed(opr_a_i) >>> w_shamt);
      OP_OR:   res_o = opr_a_i | opr_b_i;
      OP_AND:  res_o = opr_a_i & opr_b_i;
      OP_XOR:  res_o = opr_a_i ^ opr_b_i;
      OP_SLTU: res_o = XLEN'(opr_a_i < opr_b_i);
      OP_SLT:  res_o = XLEN'($signed(opr_a_i) < $signed(opr_b_i));
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts at ptr+1 and wraps; one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  int unsigned w_cand;
  logic        w_found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = (32'(ptr_i) + i) % NUM_REQ;
      if (en_i && !w_found && req_i[ID_W'(w_cand)]) begin
        gnt_o[ID_W'(w_cand)] = 1'b1;
        idx_o                = ID_W'(w_cand);
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one execute ALU among NUM_REQ requesters, round-robin, one op in flight.
// Optional per-requester stall counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = alu_pkg::XLEN,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_opr_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_opr_b_i,
  input  logic [NUM_REQ-1:0][3:0]        req_op_sel_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [XLEN-1:0]                rsp_res_o,
  output logic [NUM_REQ-1:0][31:0]       perf_stall_cnt_o
);

  localparam int unsigned CNT_W = 32;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [XLEN-1:0]     r_opr_a;
  logic [XLEN-1:0]     r_opr_b;
  logic [3:0]          r_op_sel;
  logic [ID_W-1:0]     r_id;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [XLEN-1:0]     r_rsp_res;

  logic                w_arb_en;
  logic                w_load_req;
  logic                w_load_rsp;
  logic                w_clr_rsp;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [XLEN-1:0]     w_alu_res;

  // Grant is combinational from rsp_ready_i in RESP; reset forces it low.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .en_i    (w_arb_en && resetn),
    .gnt_o   (w_gnt),
    .idx_o   (w_gnt_idx)
  );

  assign req_ready_o = w_gnt;

  execute #(
    .XLEN     (XLEN)
  ) u_execute (
    .opr_a_i  (r_opr_a),
    .opr_b_i  (r_opr_b),
    .op_sel_i (r_op_sel),
    .res_o    (w_alu_res)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    w_load_req  = 1'b0;
    w_load_rsp  = 1'b0;
    w_clr_rsp   = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
        if (|w_gnt) begin
          w_load_req  = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_load_rsp  = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_clr_rsp = 1'b1;
          w_arb_en  = 1'b1;
          if (|w_gnt) begin
            w_load_req  = 1'b1;
            w_state_nxt = EXEC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, result capture out of EXEC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_opr_a     <= '0;
      r_opr_b     <= '0;
      r_op_sel    <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
    end else begin
      if (w_load_req) begin
        r_opr_a  <= req_opr_a_i[w_gnt_idx];
        r_opr_b  <= req_opr_b_i[w_gnt_idx];
        r_op_sel <= req_op_sel_i[w_gnt_idx];
        r_id     <= w_gnt_idx;
        r_ptr    <= w_gnt_idx;
      end
      if (w_load_rsp) begin
        r_rsp_res   <= w_alu_res;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (w_clr_rsp) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_res_o   = r_rsp_res;

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles a requester is valid but not granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (req_valid_i[k] && !req_ready_o[k] && (r_stall_cnt[k] != {CNT_W{1'b1}})) begin
          r_stall_cnt[k] <= r_stall_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with two requesters.
module tb_alu_arbiter;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;

  logic                         clk = 1'b0;
  logic                         resetn;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ-1:0][XLEN-1:0] req_opr_a_i;
  logic [NUM_REQ-1:0][XLEN-1:0] req_opr_b_i;
  logic [NUM_REQ-1:0][3:0]      req_op_sel_i;
  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  logic [ID_W-1:0]              rsp_id_o;
  logic [XLEN-1:0]              rsp_res_o;
  logic [NUM_REQ-1:0][31:0]     perf_stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .XLEN             (XLEN),
    .NUM_REQ          (NUM_REQ),
    .ID_W             (ID_W)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_opr_a_i      (req_opr_a_i),
    .req_opr_b_i      (req_opr_b_i),
    .req_op_sel_i     (req_op_sel_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_id_o         (rsp_id_o),
    .rsp_res_o        (rsp_res_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [0:0] k, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
    req_op_sel_i[k] = op;
    req_opr_a_i[k]  = a;
    req_opr_b_i[k]  = b;
    req_valid_i[k]  = 1'b1;
  endtask

  // Issue one op from requester k and check its result with rsp_ready_i held high.
  task automatic do_op(input string tag, input logic [0:0] k, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int n;
    rsp_ready_i = 1'b1;
    set_req(k, op, a, b);
    #1;
    n = 0;
    while (!req_ready_o[k] && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_acc"}, 64'(req_ready_o[k]), 64'd1);
    tick();
    req_valid_i[k] = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_vld"}, 64'(rsp_valid_o), 64'd1);
    check_eq({tag, "_res"}, rsp_res_o, exp);
    check_eq({tag, "_id"}, 64'(rsp_id_o), 64'(k));
    tick();
  endtask

  initial begin
    int n_gnt;
    int n_rsp;
    int cnt0;
    int cnt1;
    logic last;
    logic w;
    logic drop0;
    logic drop1;
    logic [63:0] exp_perf1;

    resetn       = 1'b0;
    req_valid_i  = 2'b11;
    req_opr_a_i  = '0;
    req_opr_b_i  = '0;
    req_op_sel_i = '0;
    rsp_ready_i  = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_res", rsp_res_o, 64'd0);
    check_eq("rst_id", 64'(rsp_id_o), 64'd0);
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_perf", 64'(perf_stall_cnt_o), 64'd0);
    req_valid_i = 2'b00;
    resetn      = 1'b1;
    tick();

    // Single request: ADD 5+7, valid one edge after the EXEC edge.
    rsp_ready_i = 1'b1;
    set_req(1'b0, 4'd0, 64'd5, 64'd7);
    #1;
    check_eq("t1_ready", 64'(req_ready_o), 64'b01);
    tick();
    req_valid_i = 2'b00;
    check_eq("t1_exec_vld", 64'(rsp_valid_o), 64'd0);
    tick();
    check_eq("t1_vld", 64'(rsp_valid_o), 64'd1);
    check_eq("t1_res", rsp_res_o, 64'd12);
    check_eq("t1_id", 64'(rsp_id_o), 64'd0);
    tick();
    check_eq("t1_drain", 64'(rsp_valid_o), 64'd0);

    do_op("slt", 1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    do_op("sra", 1'b1, 4'd4, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    do_op("sltu", 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    do_op("sll", 1'b1, 4'd2, 64'd3, 64'd62, 64'hC000_0000_0000_0000);

    // Fairness: both held valid, 4 SUB ops each, alternating from requester 0.
    rsp_ready_i = 1'b1;
    set_req(1'b0, 4'd1, 64'd10, 64'd3);
    set_req(1'b1, 4'd1, 64'd10, 64'd3);
    n_gnt = 0;
    n_rsp = 0;
    cnt0  = 0;
    cnt1  = 0;
    last  = 1'b1;
    for (int cyc = 0; cyc < 40 && n_rsp < 8; cyc++) begin
      #1;
      drop0 = 1'b0;
      drop1 = 1'b0;
      if (rsp_valid_o) begin
        check_eq("fair_res", rsp_res_o, 64'd7);
        check_eq("fair_id", 64'(rsp_id_o), 64'(last));
        n_rsp++;
      end
      if (req_ready_o != 2'b00) begin
        w = req_ready_o[1];
        check_eq("fair_onehot", 64'(req_ready_o), w ? 64'b10 : 64'b01);
        check_eq("fair_order", 64'(w), 64'(n_gnt % 2));
        if (n_gnt > 0) check_eq("fair_repeat", 64'(w == last), 64'd0);
        last = w;
        n_gnt++;
        if (w) begin
          cnt1++;
          drop1 = (cnt1 == 4);
        end else begin
          cnt0++;
          drop0 = (cnt0 == 4);
        end
      end
      tick();
      if (drop0) req_valid_i[0] = 1'b0;
      if (drop1) req_valid_i[1] = 1'b0;
    end
    check_eq("fair_ngnt", 64'(n_gnt), 64'd8);
    check_eq("fair_nrsp", 64'(n_rsp), 64'd8);
    req_valid_i = 2'b00;

    // Backpressure: req1 XOR held 5 cycles, req0 waits then wins in the release cycle.
    rsp_ready_i = 1'b0;
    set_req(1'b1, 4'd7, 64'hFF, 64'h0F);
    #1;
    check_eq("bp_ready1", 64'(req_ready_o), 64'b10);
    tick();
    req_valid_i[1] = 1'b0;
    set_req(1'b0, 4'd0, 64'd2, 64'd3);
    #1;
    check_eq("bp_exec_rdy", 64'(req_ready_o), 64'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_vld", 64'(rsp_valid_o), 64'd1);
      check_eq("bp_res", rsp_res_o, 64'hF0);
      check_eq("bp_id", 64'(rsp_id_o), 64'd1);
      check_eq("bp_hold_rdy", 64'(req_ready_o), 64'b00);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    check_eq("bp_rel_rdy", 64'(req_ready_o), 64'b01);
    tick();
    req_valid_i = 2'b00;
    check_eq("bp_exec_vld", 64'(rsp_valid_o), 64'd0);
    tick();
    check_eq("bp2_vld", 64'(rsp_valid_o), 64'd1);
    check_eq("bp2_res", rsp_res_o, 64'd5);
    check_eq("bp2_id", 64'(rsp_id_o), 64'd0);
    tick();

    do_op("illegal", 1'b0, 4'hF, 64'h1234, 64'h5678, 64'd0);

    // Async reset while a response is pending.
    rsp_ready_i = 1'b0;
    set_req(1'b0, 4'd5, 64'hF0, 64'h0F);
    tick();
    req_valid_i = 2'b00;
    tick();
    check_eq("rr_pre_vld", 64'(rsp_valid_o), 64'd1);
    check_eq("rr_pre_res", rsp_res_o, 64'hFF);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rr_vld", 64'(rsp_valid_o), 64'd0);
    check_eq("rr_res", rsp_res_o, 64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Async reset during EXEC: the op is dropped and no response appears.
    rsp_ready_i = 1'b1;
    set_req(1'b0, 4'd0, 64'd9, 64'd9);
    tick();
    req_valid_i = 2'b00;
    set_req(1'b1, 4'd0, 64'd4, 64'd4);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("re_vld", 64'(rsp_valid_o), 64'd0);
    check_eq("re_ready", 64'(req_ready_o), 64'b00);
    tick();
    req_valid_i = 2'b00;
    resetn = 1'b1;
    tick();
    check_eq("re_post_vld0", 64'(rsp_valid_o), 64'd0);
    tick();
    check_eq("re_post_vld1", 64'(rsp_valid_o), 64'd0);
    do_op("re_add", 1'b0, 4'd0, 64'd1, 64'd1, 64'd2);

    // Stall counters: req1 waits through EXEC and two held RESP cycles.
    rsp_ready_i = 1'b0;
    set_req(1'b0, 4'd0, 64'd1, 64'd2);
    #1;
    check_eq("pf_acc0", 64'(req_ready_o), 64'b01);
    tick();
    req_valid_i[0] = 1'b0;
    set_req(1'b1, 4'd0, 64'd3, 64'd4);
    tick();
    tick();
    tick();
    rsp_ready_i = 1'b1;
    #1;
    check_eq("pf_acc1", 64'(req_ready_o), 64'b10);
    tick();
    req_valid_i = 2'b00;
`ifdef ALU_ARB_PERF_EN
    exp_perf1 = 64'd3;
`else
    exp_perf1 = 64'd0;
`endif
    check_eq("pf_cnt1", 64'(perf_stall_cnt_o[1]), exp_perf1);
    check_eq("pf_cnt0", 64'(perf_stall_cnt_o[0]), 64'd0);
    tick();
    check_eq("pf_res", rsp_res_o, 64'd7);
    check_eq("pf_id", 64'(rsp_id_o), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `execute` ALU instance between NUM_REQ requesters, e.g. the integer pipe and the address-generation/branch-compare path.
- Round-robin grant, one operation in flight.
- Operands and result are registered around the ALU; valid/ready handshakes on both request and response sides.
- Sits in the datapath between the issue logic and the writeback mux.

Parameters:
- XLEN, 64, operand/result width; must match `execute`.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester ID returned with the result.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_opr_a_i  in  NUM_REQ x XLEN  operand A per requester.
- req_opr_b_i  in  NUM_REQ x XLEN  operand B per requester.
- req_op_sel_i  in  NUM_REQ x 4  ALU op per requester (alu_pkg encoding).
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_id_o  out  ID_W  requester that issued the result.
- rsp_res_o  out  XLEN  ALU result.
- perf_stall_cnt_o  out  NUM_REQ x 32  per-requester stall counters (see Optional Feature).

Behaviour:
- Reset (resetn low, async):
  - State goes to IDLE and the RR pointer to 0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_res_o=0, operand/op registers 0, counters 0.
  - req_ready_o=0 while reset is asserted; any in-flight operation is dropped silently.
- FSM states:
  - IDLE:
    - Arbiter picks a winner among req_valid_i, priority starting at ptr+1 modulo NUM_REQ.
    - req_ready_o is one-hot on the winner, or 0 if none valid.
    - On handshake: latch opr_a, opr_b, op_sel and id; ptr <= winner; go to EXEC.
  - EXEC:
    - Registered operands drive the ALU.
    - Latch rsp_res_o <= ALU result and rsp_id_o <= id; rsp_valid_o <= 1; go to RESP.
    - req_ready_o=0.
  - RESP:
    - rsp_valid_o=1; rsp_res_o and rsp_id_o are stable until the handshake.
    - If rsp_ready_i=0: stay, req_ready_o=0.
    - If rsp_ready_i=1: rsp_valid_o <= 0. Arbitration runs as in IDLE in the same cycle (req_ready_o may be high). On a new handshake go to EXEC, else go to IDLE.
- Latency:
  - Request accepted at edge N gives rsp_valid_o=1 after edge N+1, i.e. the cycle after EXEC.
  - Throughput is one op per 2 cycles with rsp_ready_i tied high.
- Combinational path rsp_ready_i -> req_ready_o is allowed and documented.
- Requesters must hold valid, operands and op stable until ready; dropping valid before ready is legal (no grant, pointer unchanged).
- Illegal op_sel: the ALU yields 0; the arbiter forwards 0 as a normal result, no error.
- Pointer advances only on a handshake, never on idle cycles.
- With a single valid requester, it is granted every opportunity.
- All requesters valid: grants rotate 0,1,...,NUM_REQ-1,0.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Per requester, a 32-bit counter increments every cycle that req_valid_i[k]=1 and req_ready_o[k]=0.
  - Counters saturate at 0xFFFF_FFFF and clear on reset only.
  - Driven on perf_stall_cnt_o.
- Undefined: no counter flops; perf_stall_cnt_o tied to 0.

Decomposition:
- alu_pkg:
  - XLEN.
  - 4-bit op_sel_e enum: OP_ADD=0, OP_SUB=1, OP_SLL=2, OP_SRL=3, OP_SRA=4, OP_OR=5, OP_AND=6, OP_XOR=7, OP_SLTU=8, OP_SLT=9.
  - FSM state enum arb_state_e {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter:
  - Parameterised on NUM_REQ.
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant plus encoded index.
- `execute` is instantiated unchanged inside alu_arbiter.

Test Plan:
- Reset then single request: req0 ADD a=5, b=7, rsp_ready_i=1 -> rsp_valid_o two edges after accept, rsp_res_o=12, rsp_id_o=0.
- Fairness: req0 and req1 held valid with 4 ops each (SUB 10-3) -> grant order 0,1,0,1,0,1,0,1, each rsp_res_o=7, no requester granted twice in a row.
- Backpressure: req1 XOR 0xFF^0x0F accepted, rsp_ready_i=0 for 5 cycles -> rsp_res_o=0xF0 stable, rsp_valid_o high; req0 valid gets no ready until the release cycle, then is accepted in that same cycle.
- SLT/SRA: SLT a=-1, b=1 -> result 1; SRA a=0x8000_0000_0000_0000, b=4 -> result 0xF800_0000_0000_0000.
- Async reset mid-op: resetn low during EXEC -> rsp_valid_o=0 immediately; after release, next req0 ADD 1+1 -> rsp_res_o=2, rsp_id_o=0.
- ALU_ARB_PERF_EN defined, req1 blocked 3 cycles behind req0 -> perf_stall_cnt_o[1]=3, perf_stall_cnt_o[0]=0; without the macro, both read 0.
